// File: rtl/lcd_arbiter_if.sv
// Bundle for the two FIFO read ports and the HD44780 bus driven by lcd_arbiter.
// The master modport is the arbiter; the slave modport is the FIFO/LCD side.
interface lcd_arbiter_if;
  logic [15:0] entry_0;
  logic        empty_0;
  logic        rd_0;
  logic [15:0] entry_1;
  logic        empty_1;
  logic        rd_1;
  logic [7:0]  lcd_data;
  logic        rs;
  logic        rw;
  logic        enable;
  logic        on;
  logic        busy;
  logic        grant;

  modport master (
    input  entry_0, empty_0, entry_1, empty_1,
    output rd_0, rd_1, lcd_data, rs, rw, enable, on, busy, grant
  );

  modport slave (
    output entry_0, empty_0, entry_1, empty_1,
    input  rd_0, rd_1, lcd_data, rs, rw, enable, on, busy, grant
  );
endinterface

// File: rtl/lcd_arbiter.sv
// Two-channel FIFO arbiter that renders each popped word as "C<n>:XXXX" on an HD44780.
// Define LCD_ARBITER_RR_EN for round-robin tie-break; default build uses fixed priority (channel 0).
//
// state | meaning
// IDLE  | waiting for a non-empty channel
// POP   | rd strobe to the granted FIFO, head word captured
// CLEAR | clear-display command byte
// CWAIT | settle time after clear
// ADDR  | DDRAM address 0 command byte
// CHAR  | seven character bytes
// DONE  | one-cycle wrap-up before IDLE
module lcd_arbiter #(
  parameter int EN_HIGH  = 2,
  parameter int EN_LOW   = 2,
  parameter int CLR_WAIT = 4
) (
  input logic          clock,
  input logic          reset,
  lcd_arbiter_if.master bus
);

  localparam int BYTE_LEN = EN_HIGH + EN_LOW;
  localparam int TMAX     = (BYTE_LEN > CLR_WAIT) ? BYTE_LEN : CLR_WAIT;
  localparam int TW       = $clog2(TMAX + 1);
  localparam logic [TW-1:0] BYTE_LOAD  = TW'(BYTE_LEN - 1);
  localparam logic [TW-1:0] CWAIT_LOAD = TW'(CLR_WAIT - 1);
  localparam logic [TW-1:0] EN_LOW_T   = TW'(EN_LOW);

  typedef enum logic [2:0] {IDLE, POP, CLEAR, CWAIT, ADDR, CHAR, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    char_q, char_d;
  logic [15:0]   word_q, word_d;
  logic          grant_q, grant_d;
  logic          sel_valid, sel_ch;
  logic          tc, strobe_hi;
  logic [7:0]    char_byte;
`ifdef LCD_ARBITER_RR_EN
  logic          rr_q, rr_d;
`endif

  function automatic logic [7:0] nib_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    sel_valid = !bus.empty_0 || !bus.empty_1;
`ifdef LCD_ARBITER_RR_EN
    if (!bus.empty_0 && !bus.empty_1) sel_ch = rr_q;
    else                              sel_ch = bus.empty_0;
`else
    sel_ch = bus.empty_0;
`endif
  end

  always_comb begin
    case (char_q)
      3'd0:    char_byte = 8'h43;
      3'd1:    char_byte = 8'h30 + {7'h00, grant_q};
      3'd2:    char_byte = 8'h3A;
      3'd3:    char_byte = nib_char(word_q[15:12]);
      3'd4:    char_byte = nib_char(word_q[11:8]);
      3'd5:    char_byte = nib_char(word_q[7:4]);
      default: char_byte = nib_char(word_q[3:0]);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      char_q  <= '0;
      word_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      char_q  <= char_d;
      word_q  <= word_d;
      grant_q <= grant_d;
    end
  end

`ifdef LCD_ARBITER_RR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`endif

  // Timer counts down through each byte; enable is high while the count is in its upper EN_HIGH values.
  assign tc        = (timer_q == '0);
  assign strobe_hi = (timer_q >= EN_LOW_T);
  assign bus.rw    = 1'b0;
  assign bus.on    = 1'b1;
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    char_d       = char_q;
    word_d       = word_q;
    grant_d      = grant_q;
`ifdef LCD_ARBITER_RR_EN
    rr_d         = rr_q;
`endif
    bus.rd_0     = 1'b0;
    bus.rd_1     = 1'b0;
    bus.lcd_data = 8'h00;
    bus.rs       = 1'b0;
    bus.enable   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = POP;
          grant_d = sel_ch;
`ifdef LCD_ARBITER_RR_EN
          rr_d    = ~sel_ch;
`endif
        end
      end
      POP: begin
        bus.rd_0 = !grant_q;
        bus.rd_1 = grant_q;
        word_d   = grant_q ? bus.entry_1 : bus.entry_0;
        timer_d  = BYTE_LOAD;
        state_d  = CLEAR;
      end
      CLEAR: begin
        bus.lcd_data = 8'h01;
        bus.enable   = strobe_hi;
        if (tc) begin
          timer_d = CWAIT_LOAD;
          state_d = CWAIT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      CWAIT: begin
        if (tc) begin
          timer_d = BYTE_LOAD;
          state_d = ADDR;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ADDR: begin
        bus.lcd_data = 8'h80;
        bus.enable   = strobe_hi;
        if (tc) begin
          timer_d = BYTE_LOAD;
          char_d  = 3'd0;
          state_d = CHAR;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      CHAR: begin
        bus.lcd_data = char_byte;
        bus.rs       = 1'b1;
        bus.enable   = strobe_hi;
        if (tc) begin
          timer_d = BYTE_LOAD;
          if (char_q == 3'd6) state_d = DONE;
          else                char_d  = char_q + 3'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter: FIFO models feed the channels, expected bytes and
// grants are queued at stimulus time and a negedge monitor pops and compares them.
module tb_lcd_arbiter;
  localparam int EN_HIGH  = 2;
  localparam int EN_LOW   = 2;
  localparam int CLR_WAIT = 4;
  localparam int SERVICE  = 42;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lcd_arbiter_if bus();

  lcd_arbiter #(.EN_HIGH(EN_HIGH), .EN_LOW(EN_LOW), .CLR_WAIT(CLR_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [8:0]  bq[$];
  logic        gq[$];
  logic        glitch1 = 1'b0;
  logic        glitch_val = 1'b1;

  int          prev_en = 0, high_cnt = 0, low_cnt = 0, widx = 0, busy_cnt = 0;
  logic [8:0]  lat, got, exp_b;
  logic        exp_g;
  logic        fp0, fp1;
  logic [15:0] dummy;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void drive_fifo();
    bus.empty_0 = (q0.size() == 0);
    bus.entry_0 = (q0.size() != 0) ? q0[0] : 16'h0000;
    if (glitch1) begin
      bus.empty_1 = glitch_val;
      bus.entry_1 = 16'hDEAD;
    end else begin
      bus.empty_1 = (q1.size() == 0);
      bus.entry_1 = (q1.size() != 0) ? q1[0] : 16'h0000;
    end
  endfunction

  // chars holds the four hand-computed nibble characters, MSB first.
  function automatic void expect_word(input logic ch, input logic [31:0] chars);
    gq.push_back(ch);
    bq.push_back({1'b0, 8'h01});
    bq.push_back({1'b0, 8'h80});
    bq.push_back({1'b1, 8'h43});
    bq.push_back({1'b1, ch ? 8'h31 : 8'h30});
    bq.push_back({1'b1, 8'h3A});
    for (int i = 0; i < 4; i++) bq.push_back({1'b1, chars[31-8*i -: 8]});
  endfunction

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (!bus.busy && bq.size() == 0 && gq.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  // FIFO model: a pop seen during POP takes effect just after the capturing edge.
  initial begin
    forever begin
      @(negedge clock);
      fp0 = bus.rd_0;
      fp1 = bus.rd_1;
      @(posedge clock);
      #1;
      if (fp0 && q0.size() != 0) dummy = q0.pop_front();
      if (fp1 && q1.size() != 0) dummy = q1.pop_front();
      drive_fifo();
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      prev_en  = 0;
      high_cnt = 0;
      low_cnt  = 0;
      widx     = 0;
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        check("busy_len", busy_cnt, SERVICE);
        busy_cnt = 0;
      end
      if (bus.rd_0 || bus.rd_1) begin
        check("rd_exclusive", int'(bus.rd_0 & bus.rd_1), 0);
        check("rd_first_busy_cycle", busy_cnt, 1);
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected actual rd_0=%0b rd_1=%0b required none at %0t", bus.rd_0, bus.rd_1, $time);
        end else begin
          exp_g = gq.pop_front();
          check("rd_channel", int'(bus.rd_1), int'(exp_g));
          check("grant", int'(bus.grant), int'(exp_g));
        end
        widx = 0;
      end
      got = {bus.rs, bus.lcd_data};
      if (bus.enable && prev_en == 0) begin
        if (widx == 1)      check("gap_after_clear", low_cnt, EN_LOW + CLR_WAIT);
        else if (widx >= 2) check("en_low_len", low_cnt, EN_LOW);
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte_unexpected actual=%0h required none at %0t", got, $time);
        end else begin
          exp_b = bq.pop_front();
          check("byte", int'(got), int'(exp_b));
        end
        lat      = got;
        high_cnt = 1;
        widx++;
      end else if (bus.enable) begin
        high_cnt++;
        check("byte_stable", int'(got), int'(lat));
      end else if (prev_en != 0) begin
        check("en_high_len", high_cnt, EN_HIGH);
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      prev_en = int'(bus.enable);
    end
  end

  initial begin
    drive_fifo();
    #1;
    check("rst_lcd_data", int'(bus.lcd_data), 0);
    check("rst_rs", int'(bus.rs), 0);
    check("rst_rw", int'(bus.rw), 0);
    check("rst_enable", int'(bus.enable), 0);
    check("rst_on", int'(bus.on), 1);
    check("rst_rd_0", int'(bus.rd_0), 0);
    check("rst_rd_1", int'(bus.rd_1), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_grant", int'(bus.grant), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Channel-0 basic word
    @(posedge clock); #1;
    q0.push_back(16'h12AF);
    expect_word(1'b0, 32'h3132_4146);
    drive_fifo();
    wait_drain("drain_ch0_basic");

    // Nibble boundaries on channel 1
    @(posedge clock); #1;
    q1.push_back(16'h09A0);
    expect_word(1'b1, 32'h3039_4130);
    drive_fifo();
    wait_drain("drain_nibbles");

    // empty_1 glitches while channel 0 is served; a real channel-1 word then waits for IDLE
    @(posedge clock); #1;
    q0.push_back(16'h0F00);
    expect_word(1'b0, 32'h3046_3030);
    drive_fifo();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        if (bus.busy) begin seen = 1'b1; break; end
      end
      check("busy_start", int'(seen), 1);
    end
    #1;
    glitch1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #5;
      glitch_val = ~glitch_val;
      drive_fifo();
    end
    glitch1 = 1'b0;
    q1.push_back(16'h5555);
    expect_word(1'b1, 32'h3535_3535);
    drive_fifo();
    wait_drain("drain_glitch");

    // Contention: three words per channel
    @(posedge clock); #1;
    q0.push_back(16'h0001); q0.push_back(16'h0002); q0.push_back(16'h0003);
    q1.push_back(16'hBCDE); q1.push_back(16'h7F00); q1.push_back(16'h6B2C);
`ifdef LCD_ARBITER_RR_EN
    expect_word(1'b0, 32'h3030_3031);
    expect_word(1'b1, 32'h4243_4445);
    expect_word(1'b0, 32'h3030_3032);
    expect_word(1'b1, 32'h3746_3030);
    expect_word(1'b0, 32'h3030_3033);
    expect_word(1'b1, 32'h3642_3243);
`else
    expect_word(1'b0, 32'h3030_3031);
    expect_word(1'b0, 32'h3030_3032);
    expect_word(1'b0, 32'h3030_3033);
    expect_word(1'b1, 32'h4243_4445);
    expect_word(1'b1, 32'h3746_3030);
    expect_word(1'b1, 32'h3642_3243);
`endif
    drive_fifo();
    wait_drain("drain_contention");

    // Reset during the third CHAR byte while enable is high
    @(posedge clock); #1;
    q0.push_back(16'h1234);
    expect_word(1'b0, 32'h3132_3334);
    drive_fifo();
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (widx == 5 && bus.enable) begin hit = 1'b1; break; end
      end
      check("reach_third_char", int'(hit), 1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_enable", int'(bus.enable), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_lcd_data", int'(bus.lcd_data), 0);
    check("abort_grant", int'(bus.grant), 0);
    bq.delete();
    gq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    q1.push_back(16'h00FF);
    expect_word(1'b1, 32'h3030_4646);
    drive_fifo();
    wait_drain("drain_after_reset");

    check("scoreboard_empty", bq.size() + gq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 Parameter EN_HIGH, default 2: clock cycles enable is held high per LCD byte transfer.
REQ-002 Parameter EN_LOW, default 2: clock cycles enable is held low after each falling edge, before the next byte.
REQ-003 Parameter CLR_WAIT, default 4: extra idle cycles after the clear-display byte.
REQ-004 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port entry_0, input, 16: channel-0 FIFO head word, four BCD/hex nibbles with MSB nibble first.
REQ-007 Port empty_0, input, 1: channel-0 FIFO empty flag.
REQ-008 Port rd_0, output, 1: channel-0 FIFO pop strobe.
REQ-009 Port entry_1, input, 16: channel-1 FIFO head word, same format as entry_0.
REQ-010 Port empty_1, input, 1: channel-1 FIFO empty flag.
REQ-011 Port rd_1, output, 1: channel-1 FIFO pop strobe.
REQ-012 Port lcd_data, output, 8: HD44780 data bus.
REQ-013 Port rs, output, 1: register select; 0 = command, 1 = character.
REQ-014 Port rw, output, 1: read/write select; constant 0.
REQ-015 Port enable, output, 1: LCD E strobe.
REQ-016 Port on, output, 1: LCD power/backlight; constant 1.
REQ-017 Port busy, output, 1: high while a word is being serviced.
REQ-018 Port grant, output, 1: channel currently or last serviced.

Function
REQ-019 FSM states: IDLE, POP, CLEAR, CWAIT, ADDR, CHAR, DONE.
- IDLE -> POP when a channel is selected (REQ-020).
- POP -> CLEAR after 1 cycle.
- CLEAR -> CWAIT after one byte transfer.
- CWAIT -> ADDR after CLR_WAIT cycles.
- ADDR -> CHAR after one byte transfer.
- CHAR -> DONE after 7 byte transfers.
- DONE -> IDLE after 1 cycle.
REQ-020 Channel selection in IDLE:
- A channel is eligible when its empty flag is 0.
- With one eligible channel, that channel is selected.
- With both eligible, the tie-break is set by REQ-032/033.
- grant is updated when the FSM enters POP.
REQ-021 Pop handshake:
- rd_<grant> is 1 for exactly the single POP cycle; the other rd stays 0.
- rd_0 and rd_1 are never 1 in the same cycle.
- entry_<grant> is captured into an internal 16-bit register at the end of the POP cycle.
REQ-022 empty_x is sampled only in IDLE; changes while busy have no effect.
REQ-023 Byte transfer timing:
- lcd_data and rs are set in the first cycle of the transfer and held stable for the whole transfer.
- enable is 1 for EN_HIGH cycles, then 0 for EN_LOW cycles.
REQ-024 Byte sequence per word:
- 0x01 (rs=0, clear display).
- 0x80 (rs=0, DDRAM address 0).
- 0x43 'C' (rs=1).
- 0x30+grant (rs=1).
- 0x3A ':' (rs=1).
- Four nibble characters, MSB nibble first (rs=1).
REQ-025 Nibble-to-character mapping: n in 0..9 -> 0x30+n; n in 10..15 -> 0x37+n (0x41..0x46).
REQ-026 busy is 1 from POP through DONE inclusive, and 0 in IDLE.
REQ-027 Service time per word is 1 + 9*(EN_HIGH+EN_LOW) + CLR_WAIT + 1 cycles; 42 cycles with default parameters.
REQ-028 A request pending during DONE is served at the next IDLE evaluation; IDLE lasts at least 1 cycle between words.

Reset
REQ-029 While reset=1, outputs are forced asynchronously: lcd_data=0x00, rs=0, rw=0, enable=0, on=1, rd_0=0, rd_1=0, busy=0, grant=0.
REQ-030 While reset=1, the FSM is in IDLE, the captured word is 0x0000, and the round-robin pointer selects channel 0 first.
REQ-031 Reset asserted mid-transfer aborts the word:
- The abort takes effect immediately; there is no partial byte completion after release.
- The popped word is discarded.

Configuration
REQ-032 With macro LCD_ARBITER_RR_EN defined, tie-break is round-robin: the channel not granted last wins.
REQ-033 Without LCD_ARBITER_RR_EN, tie-break is fixed priority: channel 0 always wins, and channel 1 is served only when empty_0=1 in IDLE.

Verification
REQ-034 Channel-0 basic word:
- Stimulus: empty_0=0, entry_0=0x12AF, empty_1=1.
- Response: one rd_0 pulse; bytes 01,80,43,30,3A,31,32,41,46 with rs=0,0,1,1,1,1,1,1,1; busy high for 42 cycles; grant=0.
REQ-035 Nibble boundaries:
- Stimulus: entry_1=0x09A0 on channel 1 only.
- Response: character bytes 43,31,3A,30,39,41,30; grant=1.
REQ-036 Contention:
- Stimulus: both channels hold 3 words each.
- Response with LCD_ARBITER_RR_EN: grants 0,1,0,1,0,1.
- Response without it: grants 0,0,0,1,1,1.
REQ-037 Empty flags while busy:
- Stimulus: empty_1 toggles during service of a channel-0 word.
- Response: no rd_1 until IDLE is re-entered.
REQ-038 Reset mid-word:
- Stimulus: reset asserted during the third CHAR byte with enable=1.
- Response: enable=0 and busy=0 without waiting for a clock edge; after release, the next word restarts with byte 0x01.
REQ-039 Strobe timing:
- Check: every byte has enable high exactly EN_HIGH cycles and low exactly EN_LOW cycles.
- Check: lcd_data and rs are unchanged throughout the enable-high window.
